// File: rtl/key_action_decoder.sv
// PS/2 scancode decoder: turns make/break codes into one-cycle game and menu pulses,
// tracks held gameplay keys and auto-repeats the most recently pressed movement key.
module key_action_decoder #(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tick,
  output logic       left_p,
  output logic       right_p,
  output logic       down_p,
  output logic       rotate_p,
  output logic       start_p,
  output logic       gameover_p,
  output logic       easy_p,
  output logic       medium_p,
  output logic       hard_p,
  output logic [3:0] held,
  output logic [7:0] last_code,
  output logic       last_ext
);

  localparam int CW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(REPEAT_DELAY - REPEAT_RATE);

  // Bit order {rotate, down, right, left} and {hard, medium, easy, gameover, start}
  localparam logic [31:0] GP_CODE   = {8'h1D, 8'h1B, 8'h23, 8'h1C};
  localparam logic [31:0] GP_EXT    = {8'h75, 8'h72, 8'h74, 8'h6B};
  localparam logic [39:0] MENU_CODE = {8'h26, 8'h1E, 8'h16, 8'h66, 8'h5A};

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    held_reg, held_next;
  logic [3:0]    gp_pulse_reg, gp_pulse_next;
  logic [4:0]    menu_pulse_reg, menu_pulse_next;
  logic [7:0]    code_reg, code_next;
  logic          ext_reg, ext_next;
  logic [2:0]    target_reg, target_next;
  logic [CW-1:0] rep_cnt_reg, rep_cnt_next;

  logic       is_make, is_break, key_ext, new_target;
  logic [3:0] gp_hit, press;
  logic [4:0] menu_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_gp_hit
      assign gp_hit[gi] = key_ext ? (rx_data == GP_EXT[gi*8 +: 8])
                                  : (rx_data == GP_CODE[gi*8 +: 8]);
    end
    for (gi = 0; gi < 5; gi++) begin : g_menu_hit
      assign menu_hit[gi] = !key_ext && (rx_data == MENU_CODE[gi*8 +: 8]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    is_make    = 1'b0;
    is_break   = 1'b0;
    key_ext    = 1'b0;
    if (rx_valid) begin
      case (state_reg)
        IDLE: begin
          if (rx_data == 8'hE0)      state_next = GOT_E0;
          else if (rx_data == 8'hF0) state_next = GOT_F0;
          else if (rx_data != 8'hE1) is_make = 1'b1;
        end
        GOT_E0: begin
          if (rx_data == 8'hF0) state_next = GOT_E0F0;
          else if (rx_data != 8'hE0) begin
            is_make    = 1'b1;
            key_ext    = 1'b1;
            state_next = IDLE;
          end
        end
        GOT_F0: begin
          is_break   = 1'b1;
          state_next = IDLE;
        end
        default: begin
          is_break   = 1'b1;
          key_ext    = 1'b1;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    held_next       = held_reg;
    gp_pulse_next   = 4'b0000;
    menu_pulse_next = 5'b00000;
    code_next       = code_reg;
    ext_next        = ext_reg;
    target_next     = target_reg;
    rep_cnt_next    = rep_cnt_reg;
    new_target      = 1'b0;
    press           = 4'b0000;

    if (is_make) begin
      code_next       = rx_data;
      ext_next        = key_ext;
      menu_pulse_next = menu_hit;
      press           = gp_hit & ~held_reg;
      held_next       = held_reg | press;
      gp_pulse_next   = press;
      if (|press[2:0]) begin
        target_next  = press[2:0];
        rep_cnt_next = '0;
        new_target   = 1'b1;
      end
    end

    if (is_break) begin
      held_next = held_reg & ~gp_hit;
      if (|(gp_hit[2:0] & target_reg)) target_next = 3'b000;
    end

    // A byte that creates a new target swallows a coincident tick
    if (tick && !new_target && |(target_next & held_next[2:0])) begin
      if (rep_cnt_reg == CNT_MAX) begin
        gp_pulse_next[2:0] = gp_pulse_next[2:0] | target_next;
        rep_cnt_next       = CNT_RELOAD;
      end else begin
        rep_cnt_next = rep_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_reg      <= IDLE;
      held_reg       <= 4'b0000;
      gp_pulse_reg   <= 4'b0000;
      menu_pulse_reg <= 5'b00000;
      code_reg       <= 8'h00;
      ext_reg        <= 1'b0;
      target_reg     <= 3'b000;
      rep_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      held_reg       <= held_next;
      gp_pulse_reg   <= gp_pulse_next;
      menu_pulse_reg <= menu_pulse_next;
      code_reg       <= code_next;
      ext_reg        <= ext_next;
      target_reg     <= target_next;
      rep_cnt_reg    <= rep_cnt_next;
    end
  end

  assign {rotate_p, down_p, right_p, left_p}             = gp_pulse_reg;
  assign {hard_p, medium_p, easy_p, gameover_p, start_p} = menu_pulse_reg;
  assign held      = held_reg;
  assign last_code = code_reg;
  assign last_ext  = ext_reg;

endmodule

// File: tb/tb_key_action_decoder.sv
// Directed bench for key_action_decoder: scancode sequences with hand-computed
// pulse counts, held flags and last-code values.
module tb_key_action_decoder;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tick     = 1'b0;
  logic       left_p, right_p, down_p, rotate_p;
  logic       start_p, gameover_p, easy_p, medium_p, hard_p;
  logic [3:0] held;
  logic [7:0] last_code;
  logic       last_ext;
  logic [8:0] pulses;

  int vectors = 0;
  int errors  = 0;
  int cnt_arr [9];
  int base    [9];

  always #5 CLOCK_50 = ~CLOCK_50;

  key_action_decoder dut (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tick       (tick),
    .left_p     (left_p),
    .right_p    (right_p),
    .down_p     (down_p),
    .rotate_p   (rotate_p),
    .start_p    (start_p),
    .gameover_p (gameover_p),
    .easy_p     (easy_p),
    .medium_p   (medium_p),
    .hard_p     (hard_p),
    .held       (held),
    .last_code  (last_code),
    .last_ext   (last_ext)
  );

  // index: 0 left 1 right 2 down 3 rotate 4 start 5 gameover 6 easy 7 medium 8 hard
  assign pulses = {hard_p, medium_p, easy_p, gameover_p, start_p,
                   rotate_p, down_p, right_p, left_p};

  initial for (int k = 0; k < 9; k++) cnt_arr[k] = 0;

  always @(negedge CLOCK_50) begin
    for (int k = 0; k < 9; k++) cnt_arr[k] <= cnt_arr[k] + int'(pulses[k]);
  end

  task automatic send_byte(input logic [7:0] b, input logic with_tick);
    @(negedge CLOCK_50);
    rx_data  = b;
    rx_valid = 1'b1;
    tick     = with_tick;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    tick     = 1'b0;
    #1;
    $display("byte %02h tick=%0b: pulses=%09b held=%04b last=%02h/%0b",
             b, with_tick, pulses, held, last_code, last_ext);
  endtask

  task automatic do_tick();
    @(negedge CLOCK_50);
    tick = 1'b1;
    @(negedge CLOCK_50);
    tick = 1'b0;
    #1;
  endtask

  task automatic snap();
    for (int k = 0; k < 9; k++) base[k] = cnt_arr[k];
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (held !== 4'b0000) begin errors++; $display("FAIL reset_held: got %b expected 0000", held); end
    vectors++;
    if (last_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h expected 00", last_code); end
    vectors++;
    if (last_ext !== 1'b0) begin errors++; $display("FAIL reset_ext: got %b expected 0", last_ext); end
    vectors++;
    if (pulses !== 9'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0", pulses); end
    @(negedge CLOCK_50);
    Resetn = 1'b1;
  endtask

  task automatic test_left();
    snap();
    send_byte(8'h1C, 1'b0);
    vectors++;
    if (left_p !== 1'b1) begin errors++; $display("FAIL left_press_timing: got %b expected 1", left_p); end
    vectors++;
    if (held !== 4'b0001) begin errors++; $display("FAIL left_held_set: got %b expected 0001", held); end
    @(negedge CLOCK_50); #1;
    vectors++;
    if (left_p !== 1'b0) begin errors++; $display("FAIL left_pulse_width: got %b expected 0", left_p); end
    send_byte(8'hF0, 1'b0);
    vectors++;
    if (held !== 4'b0001) begin errors++; $display("FAIL left_held_mid_break: got %b expected 0001", held); end
    send_byte(8'h1C, 1'b0);
    vectors++;
    if (held !== 4'b0000) begin errors++; $display("FAIL left_held_clear: got %b expected 0000", held); end
    vectors++;
    if ({last_code, last_ext} !== {8'h1C, 1'b0}) begin
      errors++; $display("FAIL left_last: got %h/%b expected 1c/0", last_code, last_ext);
    end
    @(negedge CLOCK_50); #1;
    vectors++;
    if (cnt_arr[0] - base[0] !== 1) begin errors++; $display("FAIL left_count: got %0d expected 1", cnt_arr[0] - base[0]); end
  endtask

  task automatic test_rotate();
    int total;
    snap();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    vectors++;
    if (held !== 4'b1000) begin errors++; $display("FAIL rot_held_set: got %b expected 1000", held); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    vectors++;
    if (held !== 4'b0000) begin errors++; $display("FAIL rot_held_clear: got %b expected 0000", held); end
    vectors++;
    if ({last_code, last_ext} !== {8'h75, 1'b1}) begin
      errors++; $display("FAIL rot_last: got %h/%b expected 75/1", last_code, last_ext);
    end
    @(negedge CLOCK_50); #1;
    total = 0;
    for (int k = 0; k < 9; k++) total += cnt_arr[k] - base[k];
    vectors++;
    if (cnt_arr[3] - base[3] !== 1 || total !== 1) begin
      errors++; $display("FAIL rot_count: got rotate=%0d total=%0d expected 1/1", cnt_arr[3] - base[3], total);
    end
  endtask

  task automatic test_repeat();
    logic exp;
    snap();
    send_byte(8'h23, 1'b0);
    vectors++;
    if (right_p !== 1'b1) begin errors++; $display("FAIL rep_press: got %b expected 1", right_p); end
    for (int t = 1; t <= 14; t++) begin
      do_tick();
      exp = (t >= 8) && (t % 2 == 0);
      vectors++;
      if (right_p !== exp) begin errors++; $display("FAIL rep_tick%0d: got %b expected %b", t, right_p, exp); end
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    for (int t = 0; t < 6; t++) do_tick();
    @(negedge CLOCK_50); #1;
    vectors++;
    if (cnt_arr[1] - base[1] !== 5) begin errors++; $display("FAIL rep_count: got %0d expected 5", cnt_arr[1] - base[1]); end
  endtask

  task automatic test_typematic();
    snap();
    repeat (3) send_byte(8'h1C, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    repeat (2) send_byte(8'h5A, 1'b0);
    vectors++;
    if (held !== 4'b0000) begin errors++; $display("FAIL typ_held: got %b expected 0000", held); end
    @(negedge CLOCK_50); #1;
    vectors++;
    if (cnt_arr[0] - base[0] !== 1) begin errors++; $display("FAIL typ_left: got %0d expected 1", cnt_arr[0] - base[0]); end
    vectors++;
    if (cnt_arr[4] - base[4] !== 2) begin errors++; $display("FAIL typ_start: got %0d expected 2", cnt_arr[4] - base[4]); end
  endtask

  task automatic test_menu_misc();
    snap();
    send_byte(8'h66, 1'b0);
    send_byte(8'h16, 1'b0);
    send_byte(8'h1E, 1'b0);
    send_byte(8'h26, 1'b0);
    send_byte(8'hE1, 1'b0);
    vectors++;
    if (last_code !== 8'h26) begin errors++; $display("FAIL e1_ignored: got %h expected 26", last_code); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'h11, 1'b0);
    vectors++;
    if ({last_code, last_ext} !== {8'h11, 1'b1}) begin
      errors++; $display("FAIL ext_unmapped_last: got %h/%b expected 11/1", last_code, last_ext);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h5A, 1'b0);
    vectors++;
    if ({last_code, last_ext} !== {8'h11, 1'b1}) begin
      errors++; $display("FAIL break_keeps_last: got %h/%b expected 11/1", last_code, last_ext);
    end
    @(negedge CLOCK_50); #1;
    vectors++;
    if ({cnt_arr[8] - base[8], cnt_arr[7] - base[7], cnt_arr[6] - base[6], cnt_arr[5] - base[5], cnt_arr[4] - base[4]}
        !== {32'sd1, 32'sd1, 32'sd1, 32'sd1, 32'sd0}) begin
      errors++; $display("FAIL menu_counts: got hard=%0d med=%0d easy=%0d go=%0d start=%0d expected 1/1/1/1/0",
                         cnt_arr[8] - base[8], cnt_arr[7] - base[7], cnt_arr[6] - base[6],
                         cnt_arr[5] - base[5], cnt_arr[4] - base[4]);
    end
  endtask

  task automatic test_target_release();
    snap();
    send_byte(8'h1C, 1'b0);
    send_byte(8'h23, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    repeat (10) do_tick();
    vectors++;
    if (held !== 4'b0001) begin errors++; $display("FAIL tgt_held: got %b expected 0001", held); end
    @(negedge CLOCK_50); #1;
    vectors++;
    if (cnt_arr[0] - base[0] !== 1 || cnt_arr[1] - base[1] !== 1) begin
      errors++; $display("FAIL tgt_counts: got left=%0d right=%0d expected 1/1", cnt_arr[0] - base[0], cnt_arr[1] - base[1]);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
  endtask

  task automatic test_simultaneous();
    snap();
    send_byte(8'h1C, 1'b1);
    repeat (7) do_tick();
    vectors++;
    if (cnt_arr[0] - base[0] !== 1) begin errors++; $display("FAIL sim_no_early_rep: got %0d expected 1", cnt_arr[0] - base[0]); end
    do_tick();
    vectors++;
    if (left_p !== 1'b1) begin errors++; $display("FAIL sim_rep_at_8: got %b expected 1", left_p); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h1C, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    @(negedge CLOCK_50);
    Resetn = 1'b0;
    #1;
    vectors++;
    if ({held, last_code} !== {4'b0000, 8'h00}) begin
      errors++; $display("FAIL mid_reset_async: got held=%b code=%h expected 0000/00", held, last_code);
    end
    @(negedge CLOCK_50);
    Resetn = 1'b1;
    snap();
    send_byte(8'h1B, 1'b0);
    vectors++;
    if (down_p !== 1'b1) begin errors++; $display("FAIL mid_down_pulse: got %b expected 1", down_p); end
    vectors++;
    if (held !== 4'b0100) begin errors++; $display("FAIL mid_held: got %b expected 0100", held); end
    vectors++;
    if ({last_code, last_ext} !== {8'h1B, 1'b0}) begin
      errors++; $display("FAIL mid_last: got %h/%b expected 1b/0", last_code, last_ext);
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_rotate();
    test_repeat();
    test_typematic();
    test_menu_misc();
    test_target_release();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
